// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings from ALU control and the default datapath width.
// Imported by the ALU and by the ALU control decoder.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // SLT is computed as a subtraction, so it also needs b inverted and carry-in set.
    function automatic logic needs_subtract(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: a + (b ^ {sub}) + sub, with signed overflow.
// Overflow is the carry into the MSB XOR the carry out of the MSB.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-2:0] w_low;
    logic             w_c_msb;
    logic             w_msb;
    logic             w_cout;

    assign w_b = i_b ^ {WIDTH{i_sub}};

    // Split at the MSB so the carry into the sign bit is visible for overflow.
    assign {w_c_msb, w_low} = {1'b0, i_a[WIDTH-2:0]} + {1'b0, w_b[WIDTH-2:0]}
                            + {{(WIDTH-1){1'b0}}, i_sub};
    assign {w_cout, w_msb}  = {1'b0, i_a[WIDTH-1]} + {1'b0, w_b[WIDTH-1]}
                            + {1'b0, w_c_msb};

    assign o_sum = {w_msb, w_low};
    assign o_ovf = w_c_msb ^ w_cout;

endmodule

// File: rtl/alu.sv
// MIPS single-cycle ALU: combinational result/zero/overflow plus a registered copy
// (1-cycle latency) for pipelined or debug consumers.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       alucont,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] res_q,
    output logic             zero_q,
    output logic             ovf_q
);

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_as_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_zero;

    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;

    assign w_sub = needs_subtract(alucont);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_sub (w_sub),
        .i_a   (rd1),
        .i_b   (rd2),
        .o_sum (w_sum),
        .o_ovf (w_as_ovf)
    );

    // Result mux; SLT uses diff sign XOR overflow so it stays correct when rd1-rd2 overflows.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_ovf = 1'b0;
        case (alucont)
            ALU_AND: w_res = rd1 & rd2;
            ALU_OR:  w_res = rd1 | rd2;
            ALU_NOR: w_res = ~(rd1 | rd2);
            ALU_ADD: begin
                w_res = w_sum;
                w_ovf = w_as_ovf;
            end
            ALU_SUB: begin
                w_res = w_sum;
                w_ovf = w_as_ovf;
            end
            ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_as_ovf};
            default: begin
                w_res = {WIDTH{1'b0}};
                w_ovf = 1'b0;
            end
        endcase
    end

    assign w_zero = ~|w_res;

    assign res  = w_res;
    assign zero = w_zero;
    assign ovf  = w_ovf;

    // Output register stage; reset value mirrors a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res  <= {WIDTH{1'b0}};
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else if (en) begin
            r_res  <= w_res;
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
        end else begin
            r_res  <= r_res;
            r_zero <= r_zero;
            r_ovf  <= r_ovf;
        end
    end

    assign res_q  = r_res;
    assign zero_q = r_zero;
    assign ovf_q  = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Directed plus random scoreboard bench for alu: expectations are queued when
// stimulus is driven and popped when the combinational or registered outputs are sampled.
module tb_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         en;
    logic [3:0]   alucont;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic [W-1:0] res_q;
    logic         zero_q;
    logic         ovf_q;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .alucont (alucont),
        .rd1     (rd1),
        .rd2     (rd2),
        .res     (res),
        .zero    (zero),
        .ovf     (ovf),
        .res_q   (res_q),
        .zero_q  (zero_q),
        .ovf_q   (ovf_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: returns {ovf, res}
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                r = a + b;
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                r = a - b;
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                r = '0;
                v = 1'b0;
            end
        endcase
        return {v, r};
    endfunction

    task automatic push_exp(input logic [W-1:0] r, input logic v);
        exp_t e;
        e.res  = r;
        e.zero = (r == '0);
        e.ovf  = v;
        sb.push_back(e);
    endtask

    task automatic pop_exp(input string tag, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        if (sb.size() == 0) begin
            failed++;
            ok = 1'b0;
            $display("FAIL %s scoreboard empty: got nothing, required an entry", tag);
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic check_comb(input string tag);
        exp_t e;
        bit   ok;
        pop_exp(tag, e, ok);
        if (ok) begin
            tests++;
            assert (res === e.res) else begin
                failed++; $error("FAIL %s res: got %h required %h", tag, res, e.res);
            end
            tests++;
            assert (zero === e.zero) else begin
                failed++; $error("FAIL %s zero: got %b required %b", tag, zero, e.zero);
            end
            tests++;
            assert (ovf === e.ovf) else begin
                failed++; $error("FAIL %s ovf: got %b required %b", tag, ovf, e.ovf);
            end
        end
    endtask

    task automatic check_reg(input string tag);
        exp_t e;
        bit   ok;
        pop_exp(tag, e, ok);
        if (ok) begin
            tests++;
            assert (res_q === e.res) else begin
                failed++; $error("FAIL %s res_q: got %h required %h", tag, res_q, e.res);
            end
            tests++;
            assert (zero_q === e.zero) else begin
                failed++; $error("FAIL %s zero_q: got %b required %b", tag, zero_q, e.zero);
            end
            tests++;
            assert (ovf_q === e.ovf) else begin
                failed++; $error("FAIL %s ovf_q: got %b required %b", tag, ovf_q, e.ovf);
            end
        end
    endtask

    // Directed combinational step with an expectation written out by hand.
    task automatic comb_step(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] r, input logic v);
        @(negedge clk);
        alucont = op;
        rd1     = a;
        rd2     = b;
        push_exp(r, v);
        #1;
        check_comb(tag);
    endtask

    logic [3:0] ops [7];
    logic [W:0] m;

    initial begin
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1010;

        rst     = 1'b1;
        en      = 1'b0;
        alucont = 4'b0000;
        rd1     = '0;
        rd2     = '0;
        #2;
        push_exp('0, 1'b0);
        check_reg("reset_state");
        @(negedge clk);
        rst = 1'b0;

        comb_step("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        comb_step("or",       4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0);
        comb_step("nor",      4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0);
        comb_step("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        comb_step("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
        comb_step("sub_eq",   4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
        comb_step("sub_neg",  4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0);
        comb_step("sub_ovf",  4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        comb_step("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
        comb_step("slt_1_m1", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        comb_step("slt_ovf",  4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        comb_step("slt_ovf2", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        comb_step("illegal",  4'b1111, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);

        // Random operands across all opcodes against the reference model.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            alucont = ops[$urandom_range(0, 6)];
            rd1     = $urandom;
            rd2     = (i % 4 == 0) ? rd1 : $urandom;
            m       = model(alucont, rd1, rd2);
            push_exp(m[W-1:0], m[W]);
            #1;
            check_comb("random");
        end

        // Registered stage: load an overflowing ADD first so the reset has something to clear.
        @(negedge clk);
        en = 1'b1; alucont = 4'b0010; rd1 = 32'h7FFF_FFFF; rd2 = 32'h0000_0001;
        push_exp(32'h8000_0000, 1'b1);
        @(posedge clk); #1;
        check_reg("reg_load_ovf");

        @(negedge clk); #2;
        rst = 1'b1;
        push_exp('0, 1'b0);
        #1;
        check_reg("async_reset");
        push_exp(32'h8000_0000, 1'b1);
        check_comb("comb_during_rst");

        // Reset must dominate en across a rising edge.
        @(posedge clk); #1;
        push_exp('0, 1'b0);
        check_reg("rst_over_en");
        @(negedge clk);
        rst = 1'b0;

        en = 1'b1; alucont = 4'b0010; rd1 = 32'd2; rd2 = 32'd3;
        push_exp(32'd5, 1'b0);
        @(posedge clk); #1;
        check_reg("reg_add_2_3");

        @(negedge clk);
        en = 1'b0; alucont = 4'b0110; rd1 = 32'd5; rd2 = 32'd5;
        push_exp(32'd5, 1'b0);
        @(posedge clk); #1;
        check_reg("reg_hold");

        @(negedge clk);
        en = 1'b1;
        push_exp('0, 1'b0);
        @(posedge clk); #1;
        check_reg("reg_zero_load");

        @(negedge clk);
        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS datapath; sits between the register file read ports (rd1, rd2) and the writeback/branch logic.
- Combinational result and zero flag serve the single-cycle path.
- Also provides a registered copy of result and flags (1-cycle latency) for pipelined or debug consumers.
- Supports AND, OR, ADD, SUB, SLT and NOR, selected by the 4-bit alucont code from ALU control.

Parameters:
- WIDTH, 32, datapath width in bits; all operand and result widths use it.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  load enable for the registered output stage.
- alucont  input  4  operation select.
- rd1  input  WIDTH  operand A (register file read data 1).
- rd2  input  WIDTH  operand B (register file read data 2 or immediate).
- res  output  WIDTH  combinational result.
- zero  output  1  combinational; 1 when res == 0.
- ovf  output  1  combinational signed overflow; meaningful for ADD/SUB only, 0 otherwise.
- res_q  output  WIDTH  registered res.
- zero_q  output  1  registered zero.
- ovf_q  output  1  registered ovf.

Behaviour:
- Opcodes: 4'b0000 AND; 4'b0001 OR; 4'b0010 ADD; 4'b0110 SUB; 4'b0111 SLT; 4'b1100 NOR.
- Any other alucont value: res = 0, ovf = 0, so zero = 1.
- AND / OR / NOR: bitwise rd1&rd2, rd1|rd2, ~(rd1|rd2).
- ADD: res = (rd1 + rd2) mod 2^WIDTH; carry-out is discarded.
- SUB: res = (rd1 - rd2) mod 2^WIDTH, two's complement.
- SLT: res = 1 if $signed(rd1) < $signed(rd2), else 0; upper WIDTH-1 bits are 0.
  - Comparison must be correct even when the subtraction overflows; use the sign of the difference XOR the overflow bit.
- ovf, ADD: 1 when the operands have the same sign and the result sign differs.
- ovf, SUB: 1 when the operands have different signs and the result sign differs from rd1.
- ovf is 0 for all other operations.
- zero: ~|res, for every opcode including SLT and illegal codes.
- res, zero and ovf are purely combinational: no clock dependency, and they settle within the same cycle the inputs change.
- Registered stage: on the rising clk edge with en=1, res_q/zero_q/ovf_q <= res/zero/ovf. With en=0 they hold.
- Reset: rst=1 immediately (asynchronously) forces res_q=0, zero_q=1, ovf_q=0.
  - Reset dominates en.
  - Combinational outputs are unaffected by rst.
  - On deassertion, the first en=1 edge loads normally.
- Latency: 0 cycles for res/zero/ovf; 1 cycle for the _q outputs.

Decomposition:
- Shared package alu_pkg holds:
  - the alucont opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
  - the default WIDTH constant.
- The package is reused by the ALU control decoder.
- One natural sub-module: alu_addsub. It is a single shared adder with b-invert and carry-in, producing sum, carry and ovf. ADD, SUB and SLT all use it; SLT must not get a separate comparator.
- Output register stage stays inline in alu.

Test Plan:
- AND/OR/NOR with rd1=32'hF0F0_1234, rd2=32'h0FF0_FF00:
  - AND -> res=32'h00F0_1200, zero=0;
  - OR -> 32'hFFF0_FF34;
  - NOR -> 32'h000F_00CB.
- ADD:
  - 32'hFFFF_FFFF + 1 -> res=0, zero=1, ovf=0;
  - 32'h7FFF_FFFF + 1 -> res=32'h8000_0000, ovf=1.
- SUB:
  - 5 - 5 -> res=0, zero=1;
  - 3 - 5 -> res=32'hFFFF_FFFE;
  - 32'h8000_0000 - 1 -> res=32'h7FFF_FFFF, ovf=1.
- SLT:
  - rd1=32'hFFFF_FFFF (-1), rd2=1 -> res=1;
  - rd1=1, rd2=32'hFFFF_FFFF -> res=0, zero=1;
  - rd1=32'h8000_0000, rd2=32'h7FFF_FFFF -> res=1 (overflow case).
- Illegal code 4'b1111 with arbitrary operands -> res=0, zero=1, ovf=0.
- Register stage:
  - rst pulse mid-cycle -> res_q=0, zero_q=1 immediately without a clk edge;
  - then en=1, ADD 2+3 -> res_q=5, zero_q=0 after one edge;
  - en=0 with new inputs -> res_q holds 5.
